// File: rtl/piso_scheduler.sv
// Two-requester round-robin front end feeding a parallel-in/serial-out shifter.
// Each accepted word is sent MSB first, one bit every DIV clocks, followed by a one-cycle done pulse.
module piso_scheduler #(
    parameter int WIDTH = 8,
    parameter int DIV   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic             ser_out,
    output logic             ser_active,
    output logic             ser_bit_stb,
    output logic             frame_done,
    output logic             grant_id
);

    localparam int CNT_W = 8;
    localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_shift;
    logic [CNT_W-1:0] r_div_cnt;
    logic [BIT_W-1:0] r_bit_cnt;
    logic             r_last_grant;
    logic             r_grant_id;

    logic w_grant;
    logic w_xfer;
    logic w_div_wrap;
    logic w_last_bit;

    // On a tie the requester that did not win last time goes next; a lone requester always wins.
    always_comb begin
        w_grant = req1_valid;
        if (req0_valid && req1_valid) begin
            w_grant = ~r_last_grant;
        end
    end

    assign req0_ready = !rst && (r_state == IDLE) && req0_valid && !w_grant;
    assign req1_ready = !rst && (r_state == IDLE) && req1_valid && w_grant;
    assign w_xfer     = req0_ready || req1_ready;
    assign w_div_wrap = (r_div_cnt == DIV_LAST);
    assign w_last_bit = (r_bit_cnt == BIT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_xfer) begin
                    w_next_state = SHIFT;
                end
            end
            SHIFT: begin
                if (w_div_wrap && w_last_bit) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // The shift register MSB is the live serial bit; it moves on every divider wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift      <= '0;
            r_div_cnt    <= '0;
            r_bit_cnt    <= '0;
            r_last_grant <= 1'b1;
            r_grant_id   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_xfer) begin
                        r_shift      <= w_grant ? req1_data : req0_data;
                        r_div_cnt    <= '0;
                        r_bit_cnt    <= '0;
                        r_last_grant <= w_grant;
                        r_grant_id   <= w_grant;
                    end
                end
                SHIFT: begin
                    if (w_div_wrap) begin
                        r_div_cnt <= '0;
                        r_shift   <= r_shift << 1;
                        r_bit_cnt <= r_bit_cnt + BIT_W'(1);
                    end else begin
                        r_div_cnt <= r_div_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_div_cnt <= '0;
                    r_bit_cnt <= '0;
                end
            endcase
        end
    end

    assign ser_active  = (r_state == SHIFT);
    assign ser_out     = ser_active && r_shift[WIDTH-1];
    assign ser_bit_stb = ser_active && (r_div_cnt == '0);
    assign frame_done  = (r_state == DONE);
    assign grant_id    = r_grant_id;

endmodule

// File: tb/tb_piso_scheduler.sv
// Scoreboard bench for piso_scheduler: expected frames are queued when a word is offered
// and checked bit by bit against the serial stream; a second DIV=1 instance covers the fast case.
module tb_piso_scheduler;

    localparam int W     = 8;
    localparam int DV    = 4;
    localparam int FRAME = W * DV;

    typedef struct packed {
        logic         id;
        logic [W-1:0] data;
    } frame_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req1_valid;
    logic [W-1:0] req0_data, req1_data;
    logic         req0_ready, req1_ready;
    logic         ser_out, ser_active, ser_bit_stb, frame_done, grant_id;

    logic         bReq0Valid, bReq1Valid;
    logic [W-1:0] bReq0Data, bReq1Data;
    logic         bReq0Ready, bReq1Ready;
    logic         bSerOut, bSerActive, bSerBitStb, bFrameDone, bGrantId;

    int     checks = 0;
    int     failures = 0;
    int     cyc = 0;
    int     acceptCyc = 0;
    int     lastDoneCyc = 0;
    int     acceptCount = 0;
    int     doneCount = 0;
    int     seenDone = 0;
    bit     busy = 1'b0;
    bit     bbCheck = 1'b0;
    frame_t expQ[$];

    int     rel;
    logic   expAct, expDone, expStb, expBit;
    frame_t head;

    piso_scheduler #(.WIDTH(W), .DIV(DV)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .ser_out(ser_out), .ser_active(ser_active), .ser_bit_stb(ser_bit_stb),
        .frame_done(frame_done), .grant_id(grant_id)
    );

    piso_scheduler #(.WIDTH(W), .DIV(1)) dutFast (
        .clk(clk), .rst(rst),
        .req0_valid(bReq0Valid), .req0_data(bReq0Data), .req0_ready(bReq0Ready),
        .req1_valid(bReq1Valid), .req1_data(bReq1Data), .req1_ready(bReq1Ready),
        .ser_out(bSerOut), .ser_active(bSerActive), .ser_bit_stb(bSerBitStb),
        .frame_done(bFrameDone), .grant_id(bGrantId)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h cycle=%0d", tag, actual, expected, cyc);
        end
    endtask

    // Queue the frame this word should produce, then offer it on the chosen requester.
    task automatic applyStimulus(input logic id, input logic [W-1:0] data);
        frame_t f;
        f.id   = id;
        f.data = data;
        expQ.push_back(f);
        if (id) begin
            req1_data  = data;
            req1_valid = 1'b1;
        end else begin
            req0_data  = data;
            req0_valid = 1'b1;
        end
    endtask

    task automatic waitAccept(input int target, input int budget);
        int n = 0;
        while (acceptCount < target && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("wait_accept", acceptCount >= target, 1);
    endtask

    task automatic waitFrames(input int target, input int budget);
        int n = 0;
        while (doneCount < target && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("wait_frame_done", doneCount >= target, 1);
    endtask

    // Monitor: timing is measured from the observed handshake, content comes from the queue head.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                checkOutput("ready_in_reset", req0_ready | req1_ready, 0);
                if (busy && expQ.size() > 0) void'(expQ.pop_front());
                busy = 1'b0;
            end else begin
                rel     = cyc - acceptCyc;
                expAct  = busy && rel >= 1 && rel <= FRAME;
                expDone = busy && rel == FRAME + 1;
                expStb  = expAct && ((rel - 1) % DV == 0);
                expBit  = 1'b0;
                if (expAct && expQ.size() > 0) begin
                    head   = expQ[0];
                    expBit = head.data[W - 1 - (rel - 1) / DV];
                    if (rel == 1) checkOutput("grant_id_frame_start", grant_id, head.id);
                end
                if (frame_done) seenDone++;
                checkOutput("ser_active", ser_active, expAct);
                checkOutput("ser_bit_stb", ser_bit_stb, expStb);
                checkOutput("ser_out", ser_out, expBit);
                checkOutput("frame_done", frame_done, expDone);
                checkOutput("ready_exclusive", req0_ready & req1_ready, 0);
                checkOutput("ready0_without_valid", req0_ready & ~req0_valid, 0);
                checkOutput("ready1_without_valid", req1_ready & ~req1_valid, 0);
                if (busy) checkOutput("ready_while_busy", req0_ready | req1_ready, 0);
                else      checkOutput("ready_when_idle", req0_ready | req1_ready, req0_valid | req1_valid);
                if (expDone) begin
                    if (expQ.size() > 0) begin
                        checkOutput("grant_id_frame_end", grant_id, expQ[0].id);
                        void'(expQ.pop_front());
                    end
                    busy = 1'b0;
                    doneCount++;
                    lastDoneCyc = cyc;
                end
                if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
                    checkOutput("accept_has_expectation", expQ.size() > 0, 1);
                    if (expQ.size() > 0) begin
                        checkOutput("accept_requester", req1_ready, expQ[0].id);
                        checkOutput("accept_data", req1_ready ? req1_data : req0_data, expQ[0].data);
                        busy      = 1'b1;
                        acceptCyc = cyc;
                    end
                    if (bbCheck) checkOutput("back_to_back_gap", cyc - lastDoneCyc, 1);
                    acceptCount++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [W-1:0] words [3];
        logic [W-1:0] bWord;
        int base;
        int dbase;
        int seenBase;

        rst = 1'b1;
        req0_valid = 1'b1; req0_data = 8'h11;
        req1_valid = 1'b1; req1_data = 8'h22;
        bReq0Valid = 1'b1; bReq0Data = 8'h33;
        bReq1Valid = 1'b1; bReq1Data = 8'h44;

        // Reset held two cycles with both requesters asking
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("reset_ready0", req0_ready, 0);
        checkOutput("reset_ready1", req1_ready, 0);
        checkOutput("reset_ser_out", ser_out, 0);
        checkOutput("reset_ser_active", ser_active, 0);
        checkOutput("reset_ser_bit_stb", ser_bit_stb, 0);
        checkOutput("reset_frame_done", frame_done, 0);
        checkOutput("reset_grant_id", grant_id, 0);
        checkOutput("reset_fast_ready", bReq0Ready | bReq1Ready, 0);
        checkOutput("reset_fast_outputs", {bSerOut, bSerActive, bSerBitStb, bFrameDone, bGrantId}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        bReq0Valid = 1'b0; bReq1Valid = 1'b0;

        // Single frame from requester 0
        @(posedge clk); #1;
        applyStimulus(1'b0, 8'b10010011);
        @(negedge clk);
        checkOutput("single_ready0", req0_ready, 1);
        checkOutput("single_ready1", req1_ready, 0);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req0_data  = 8'hFF;
        waitFrames(1, FRAME + 10);
        checkOutput("single_done_latency", lastDoneCyc - acceptCyc, FRAME + 1);
        checkOutput("single_grant_id", grant_id, 0);

        // Arbitration: reset restores requester 0 as first winner, both held valid
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        base  = acceptCount;
        dbase = doneCount;
        applyStimulus(1'b0, 8'hA5);
        applyStimulus(1'b1, 8'h3C);
        applyStimulus(1'b0, 8'hA5);
        applyStimulus(1'b1, 8'h3C);
        waitAccept(base + 1, 20);
        bbCheck = 1'b1;
        waitAccept(base + 4, 4 * (FRAME + 2) + 10);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        bbCheck    = 1'b0;
        waitFrames(dbase + 4, 4 * (FRAME + 2) + 10);

        // Back-to-back words from requester 1, new data offered during each frame
        for (int k = 0; k < 3; k++) words[k] = 8'($urandom_range(255));
        base  = acceptCount;
        dbase = doneCount;
        applyStimulus(1'b1, words[0]);
        waitAccept(base + 1, 20);
        bbCheck = 1'b1;
        applyStimulus(1'b1, words[1]);
        waitAccept(base + 2, FRAME + 10);
        applyStimulus(1'b1, words[2]);
        waitAccept(base + 3, FRAME + 10);
        req1_valid = 1'b0;
        req1_data  = 8'h00;
        bbCheck    = 1'b0;
        waitFrames(dbase + 3, 3 * (FRAME + 2) + 10);

        // Reset during bit 3 aborts the frame without a done pulse
        base = acceptCount;
        applyStimulus(1'b0, 8'h5A);
        waitAccept(base + 1, 20);
        req0_valid = 1'b0;
        repeat (13) @(posedge clk);
        #1;
        rst = 1'b1;
        seenBase = seenDone;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("abort_ser_active", ser_active, 0);
        checkOutput("abort_ser_out", ser_out, 0);
        checkOutput("abort_ser_bit_stb", ser_bit_stb, 0);
        checkOutput("abort_frame_done", frame_done, 0);
        repeat (FRAME + 5) @(posedge clk);
        #1;
        checkOutput("abort_no_frame_done", seenDone, seenBase);
        base  = acceptCount;
        dbase = doneCount;
        applyStimulus(1'b0, 8'hC3);
        waitAccept(base + 1, 20);
        req0_valid = 1'b0;
        waitFrames(dbase + 1, FRAME + 10);

        // DIV=1 instance: one bit per cycle, strobe on every bit
        bWord      = 8'hF0;
        bReq0Data  = bWord;
        bReq0Valid = 1'b1;
        @(negedge clk);
        checkOutput("fast_ready0", bReq0Ready, 1);
        checkOutput("fast_ready1", bReq1Ready, 0);
        @(posedge clk); #1;
        bReq0Valid = 1'b0;
        bReq0Data  = 8'h0F;
        for (int i = 1; i <= W + 1; i++) begin
            @(negedge clk);
            if (i <= W) begin
                checkOutput("fast_ser_out", bSerOut, bWord[W - i]);
                checkOutput("fast_ser_bit_stb", bSerBitStb, 1);
                checkOutput("fast_ser_active", bSerActive, 1);
                checkOutput("fast_frame_done_early", bFrameDone, 0);
            end else begin
                checkOutput("fast_frame_done", bFrameDone, 1);
                checkOutput("fast_done_ser_active", bSerActive, 0);
                checkOutput("fast_done_ser_out", bSerOut, 0);
                checkOutput("fast_done_ser_bit_stb", bSerBitStb, 0);
            end
        end
        @(negedge clk);
        checkOutput("fast_idle_frame_done", bFrameDone, 0);
        checkOutput("fast_grant_id", bGrantId, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
